dmem_responder: RTL

Memory-side responder for the 16-bit multicycle processor's data/instruction fetch interface. The controller FSM acts as initiator and issues one word request at a time; this block accepts it via a valid/ready handshake, waits a configurable number of cycles, performs the access on a local word array, and returns the result on a held response channel. It replaces the zero-latency memory model with a timing-accurate responder the controller must handshake with.

---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_store.sv | 33 +++
 rtl/dmem_responder.sv | 113 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
package dmem_pkg;

    localparam int WORD_W          = 16;
    localparam int CNT_W           = 4;
    localparam int ADDR_W_DEF      = 8;
    localparam int WAIT_CYCLES_DEF = 2;

    localparam logic [WORD_W-1:0] RDATA_NONE = 16'h0000;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // True when the word address falls inside a 2**aw word array.
    function automatic logic addr_ok(input logic [WORD_W-1:0] addr, input int unsigned aw);
        return (addr >> aw) == '0;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channel between the controller (master) and the memory responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_store.sv
// Single-port synchronous word array; rdata is registered and updated only on an enabled access.
module dmem_store
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // NOTE: the array itself is never reset so it can map onto a RAM macro; only the read register clears.
    always_ff @(posedge clk) begin
        if (en && we && !rst) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= RDATA_NONE;
        end else if (en) begin
            rdata <= we ? RDATA_NONE : mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Timing-accurate memory responder: accepts one request, waits WAIT_CYCLES, accesses the array, holds the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    dmem_if.slave bus
);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              ready_q;
    logic              valid_q;
    logic              err_q;
    logic [WORD_W-1:0] store_rdata;

    logic              commit;
    logic              acc_we;
    logic [WORD_W-1:0] acc_addr;
    logic [WORD_W-1:0] acc_wdata;
    logic              acc_ok;

    // With zero wait states the access uses the live request; otherwise the latched copy.
    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can leave it unassigned and infer a latch.
        commit    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE && WAIT_CYCLES == 0) begin
            acc_we    = bus.req_we;
            acc_addr  = bus.req_addr;
            acc_wdata = bus.req_wdata;
            commit    = bus.req_valid && !rst;
        end else if (state == WAIT && cnt == '0) begin
            commit = !rst;
        end
    end

    assign acc_ok = addr_ok(acc_addr, ADDR_W);

    dmem_store #(.ADDR_W(ADDR_W)) u_store (
        .clk   (clk),
        .rst   (rst),
        .en    (commit && acc_ok),
        .we    (acc_we),
        .addr  (acc_addr[ADDR_W-1:0]),
        .wdata (acc_wdata),
        .rdata (store_rdata)
    );

    // NOTE: state updates are non-blocking so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        ready_q <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state   <= RESP;
                            valid_q <= 1'b1;
                            err_q   <= !acc_ok;
                        end else begin
                            cnt   <= CNT_W'(WAIT_CYCLES - 1);
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state   <= RESP;
                        valid_q <= 1'b1;
                        err_q   <= !acc_ok;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_rdata = err_q ? RDATA_NONE : store_rdata;

endmodule
